// File: rtl/rx_frame_parser_pkg.sv
// Shared definitions for the MAC receive frame parser and downstream header lookup logic.
// Holds descriptor layout, minimum header length, FSM encoding and header field widths.
package rx_frame_parser_pkg;

   localparam int ERR_BIT     = 15;
   localparam int LEN_MSB     = 11;
   localparam int LEN_W       = LEN_MSB + 1;
   localparam int MIN_HDR_LEN = 14;
   localparam int MAC_W       = 48;
   localparam int ETYPE_W     = 16;
   localparam int CNT_W       = 16;
   localparam int SKID_W      = 10;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_PTR   = 3'd1,
      ST_HDR   = 3'd2,
      ST_BODY  = 3'd3,
      ST_DRAIN = 3'd4
   } state_e;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/rx_skid2.sv
// Two-entry output buffer; slot0 is always the head so the presented word only
// changes on a pop, keeping data stable under backpressure.
module rx_skid2 #(
   parameter int DATA_W = 10
) (
   input  logic              clk_i,
   input  logic              rstn_i,
   input  logic              in_valid_i,
   input  logic [DATA_W-1:0] in_data_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [DATA_W-1:0] out_data_o,
   output logic [1:0]        count_o
);

   logic [DATA_W-1:0] slot0_q, slot0_d, slot1_q, slot1_d;
   logic [1:0]        cnt_q, cnt_d;
   logic              pop;

   assign out_valid_o = (cnt_q != 2'd0);
   assign out_data_o  = slot0_q;
   assign count_o     = cnt_q;
   assign pop         = out_valid_o & out_ready_i;

   always_comb begin
      slot0_d = slot0_q;
      slot1_d = slot1_q;
      cnt_d   = cnt_q;
      case ({in_valid_i, pop})
         2'b10: begin
            if (cnt_q == 2'd0) slot0_d = in_data_i;
            else               slot1_d = in_data_i;
            cnt_d = cnt_q + 2'd1;
         end
         2'b01: begin
            slot0_d = slot1_q;
            cnt_d   = cnt_q - 2'd1;
         end
         2'b11: begin
            if (cnt_q == 2'd1) begin
               slot0_d = in_data_i;
            end else begin
               slot0_d = slot1_q;
               slot1_d = in_data_i;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         slot0_q <= '0;
         slot1_q <= '0;
         cnt_q   <= 2'd0;
      end else begin
         slot0_q <= slot0_d;
         slot1_q <= slot1_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: rtl/rx_frame_parser.sv
// Pops MAC rx descriptors, forwards good frames byte-by-byte with sof/eof, captures
// DA/SA/EtherType into a header descriptor, and drains errored or runt frames.
module rx_frame_parser
   import rx_frame_parser_pkg::*;
(
   input  logic               clk,
   input  logic               rstn,
   output logic               ptr_fifo_rd,
   input  logic [15:0]        ptr_fifo_dout,
   input  logic               ptr_fifo_empty,
   output logic               data_fifo_rd,
   input  logic [7:0]         data_fifo_dout,
   output logic [7:0]         out_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               out_sof,
   output logic               out_eof,
   output logic               hdr_valid,
   input  logic               hdr_ready,
   output logic [MAC_W-1:0]   hdr_da,
   output logic [MAC_W-1:0]   hdr_sa,
   output logic [ETYPE_W-1:0] hdr_etype,
   output logic [LEN_W-1:0]   hdr_len,
   output logic [CNT_W-1:0]   runt_cnt,
   output logic [CNT_W-1:0]   err_cnt
);

   state_e              state_q, state_d;
   logic [LEN_W-1:0]    len_q, len_d, rd_cnt_q, rd_cnt_d, arr_cnt_q, arr_cnt_d;
   logic                fwd_q, fwd_d, hdr_valid_q, hdr_valid_d;
   logic [CNT_W-1:0]    runt_q, runt_d, err_q, err_d;
   logic [MAC_W-1:0]    da_q, da_d, sa_q, sa_d;
   logic [ETYPE_W-1:0]  etype_q, etype_d;
   logic [LEN_W-1:0]    ptr_len;
   logic                ptr_err, push, pop, can_rd, rd_more, last_arr, hdr_done;
   logic [1:0]          skid_cnt;
   logic [2:0]          occ;
   logic [SKID_W-1:0]   skid_dout;
   logic                unused_rsvd;

   assign ptr_len     = ptr_fifo_dout[LEN_MSB:0];
   assign ptr_err     = ptr_fifo_dout[ERR_BIT];
   assign unused_rsvd = ^ptr_fifo_dout[14:12];

   // fwd_q marks a forwarded byte landing on data_fifo_dout this cycle.
   assign push     = fwd_q;
   assign pop      = out_valid & out_ready;
   assign occ      = {1'b0, skid_cnt} + {2'b00, fwd_q};
   assign can_rd   = occ < (3'd2 + {2'b00, pop});
   assign rd_more  = (rd_cnt_q != len_q);
   assign last_arr = (arr_cnt_q == (len_q - 1'b1));
   assign hdr_done = push && (state_q == ST_HDR) && (arr_cnt_q == LEN_W'(MIN_HDR_LEN - 1));
   assign fwd_d    = data_fifo_rd && ((state_q == ST_HDR) || (state_q == ST_BODY));

   always_comb begin
      state_d      = state_q;
      len_d        = len_q;
      rd_cnt_d     = rd_cnt_q;
      arr_cnt_d    = arr_cnt_q;
      hdr_valid_d  = hdr_valid_q;
      runt_d       = runt_q;
      err_d        = err_q;
      da_d         = da_q;
      sa_d         = sa_q;
      etype_d      = etype_q;
      ptr_fifo_rd  = 1'b0;
      data_fifo_rd = 1'b0;

      if (hdr_valid_q && hdr_ready) hdr_valid_d = 1'b0;
      if (push) arr_cnt_d = arr_cnt_q + 1'b1;
      if (push && (state_q == ST_HDR)) begin
         if (arr_cnt_q < LEN_W'(6))       da_d    = {da_q[MAC_W-9:0], data_fifo_dout};
         else if (arr_cnt_q < LEN_W'(12)) sa_d    = {sa_q[MAC_W-9:0], data_fifo_dout};
         else                             etype_d = {etype_q[7:0], data_fifo_dout};
      end

      case (state_q)
         ST_IDLE: begin
            if (!ptr_fifo_empty && !hdr_valid_q) begin
               ptr_fifo_rd = 1'b1;
               state_d     = ST_PTR;
            end
         end
         ST_PTR: begin
            len_d     = ptr_len;
            rd_cnt_d  = '0;
            arr_cnt_d = '0;
            if (ptr_err) begin
               err_d   = sat_inc(err_q);
               state_d = (ptr_len == '0) ? ST_IDLE : ST_DRAIN;
            end else if (ptr_len < LEN_W'(MIN_HDR_LEN)) begin
               runt_d  = sat_inc(runt_q);
               state_d = (ptr_len == '0) ? ST_IDLE : ST_DRAIN;
            end else begin
               state_d = ST_HDR;
            end
         end
         ST_HDR, ST_BODY: begin
            if (rd_more && can_rd) begin
               data_fifo_rd = 1'b1;
               rd_cnt_d     = rd_cnt_q + 1'b1;
            end
            if (hdr_done) begin
               hdr_valid_d = 1'b1;
               state_d     = (len_q == LEN_W'(MIN_HDR_LEN)) ? ST_IDLE : ST_BODY;
            end else if (push && (state_q == ST_BODY) && last_arr) begin
               state_d = ST_IDLE;
            end
         end
         ST_DRAIN: begin
            data_fifo_rd = 1'b1;
            rd_cnt_d     = rd_cnt_q + 1'b1;
            if (rd_cnt_q == (len_q - 1'b1)) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= ST_IDLE;
         len_q       <= '0;
         rd_cnt_q    <= '0;
         arr_cnt_q   <= '0;
         fwd_q       <= 1'b0;
         hdr_valid_q <= 1'b0;
         runt_q      <= '0;
         err_q       <= '0;
         da_q        <= '0;
         sa_q        <= '0;
         etype_q     <= '0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         rd_cnt_q    <= rd_cnt_d;
         arr_cnt_q   <= arr_cnt_d;
         fwd_q       <= fwd_d;
         hdr_valid_q <= hdr_valid_d;
         runt_q      <= runt_d;
         err_q       <= err_d;
         da_q        <= da_d;
         sa_q        <= sa_d;
         etype_q     <= etype_d;
      end
   end

   rx_skid2 #(.DATA_W(SKID_W)) u_skid (
      .clk_i       (clk),
      .rstn_i      (rstn),
      .in_valid_i  (push),
      .in_data_i   ({arr_cnt_q == '0, last_arr, data_fifo_dout}),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_data_o  (skid_dout),
      .count_o     (skid_cnt)
   );

   assign {out_sof, out_eof, out_data} = skid_dout;
   assign hdr_valid = hdr_valid_q;
   assign hdr_da    = da_q;
   assign hdr_sa    = sa_q;
   assign hdr_etype = etype_q;
   assign hdr_len   = len_q;
   assign runt_cnt  = runt_q;
   assign err_cnt   = err_q;

endmodule

// File: tb/tb_rx_frame_parser.sv
// Directed bench for rx_frame_parser: FIFO models feed descriptors and bytes, a monitor
// logs accepted bytes/headers, and queued expectations are compared as frames complete.
module tb_rx_frame_parser;

   logic         clk = 1'b0;
   logic         rstn;
   logic         ptr_fifo_rd, ptr_fifo_empty, data_fifo_rd;
   logic [15:0]  ptr_fifo_dout;
   logic [7:0]   data_fifo_dout, out_data;
   logic         out_valid, out_ready, out_sof, out_eof;
   logic         hdr_valid, hdr_ready;
   logic [47:0]  hdr_da, hdr_sa;
   logic [15:0]  hdr_etype, runt_cnt, err_cnt;
   logic [11:0]  hdr_len;

   logic [15:0]  ptr_mem [0:31];
   logic [7:0]   data_mem [0:2047];
   int           ptr_push, ptr_pop, data_wr, data_rd, underflow, stab_viol;
   logic [9:0]   obs_b [$];
   logic [123:0] obs_h [$];
   logic [9:0]   exp_b [$];
   logic [123:0] exp_h [$];
   int           obs_bi, obs_hi;
   int           n_assert, n_fail;
   logic         stall_q;
   logic [9:0]   stall_d;

   always #5 clk = ~clk;

   rx_frame_parser dut (
      .clk            (clk),
      .rstn           (rstn),
      .ptr_fifo_rd    (ptr_fifo_rd),
      .ptr_fifo_dout  (ptr_fifo_dout),
      .ptr_fifo_empty (ptr_fifo_empty),
      .data_fifo_rd   (data_fifo_rd),
      .data_fifo_dout (data_fifo_dout),
      .out_data       (out_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_sof        (out_sof),
      .out_eof        (out_eof),
      .hdr_valid      (hdr_valid),
      .hdr_ready      (hdr_ready),
      .hdr_da         (hdr_da),
      .hdr_sa         (hdr_sa),
      .hdr_etype      (hdr_etype),
      .hdr_len        (hdr_len),
      .runt_cnt       (runt_cnt),
      .err_cnt        (err_cnt)
   );

   assign ptr_fifo_empty = (ptr_push == ptr_pop);

   // One-cycle-latency FIFO models; reset flushes whatever is queued.
   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ptr_pop        <= ptr_push;
         data_rd        <= data_wr;
         ptr_fifo_dout  <= '0;
         data_fifo_dout <= '0;
      end else begin
         if (ptr_fifo_rd) begin
            if (ptr_pop == ptr_push) underflow <= underflow + 1;
            ptr_fifo_dout <= ptr_mem[ptr_pop[4:0]];
            ptr_pop       <= ptr_pop + 1;
         end
         if (data_fifo_rd) begin
            if (data_rd == data_wr) underflow <= underflow + 1;
            data_fifo_dout <= data_mem[data_rd[10:0]];
            data_rd        <= data_rd + 1;
         end
      end
   end

   always @(negedge clk) begin
      if (rstn) begin
         if (out_valid && out_ready) obs_b.push_back({out_sof, out_eof, out_data});
         if (hdr_valid && hdr_ready) obs_h.push_back({hdr_da, hdr_sa, hdr_etype, hdr_len});
         if (stall_q && !(out_valid && ({out_sof, out_eof, out_data} == stall_d)))
            stab_viol = stab_viol + 1;
         stall_q = out_valid && !out_ready;
         stall_d = {out_sof, out_eof, out_data};
      end else begin
         stall_q = 1'b0;
      end
   end

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] byte_of(input int seed, input int i);
      return 8'((seed * 29) + (i * 13) + 1);
   endfunction

   task automatic send_frame(input int len, input bit err, input bit fwd, input int seed);
      logic [47:0] da, sa;
      logic [15:0] et;
      logic [7:0]  b;
      da = '0; sa = '0; et = '0;
      for (int i = 0; i < len; i++) begin
         b = byte_of(seed, i);
         data_mem[data_wr[10:0]] = b;
         data_wr++;
         if (i < 6)       da = {da[39:0], b};
         else if (i < 12) sa = {sa[39:0], b};
         else if (i < 14) et = {et[7:0], b};
         if (fwd) exp_b.push_back({i == 0, i == len - 1, b});
      end
      if (fwd) exp_h.push_back({da, sa, et, 12'(len)});
      ptr_mem[ptr_push[4:0]] = {err, 3'b000, 12'(len)};
      ptr_push++;
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_bytes(input int target, input bit toggle);
      int n;
      n = 0;
      while (obs_b.size() < target && n < 3000) begin
         @(posedge clk);
         #1;
         if (toggle) out_ready = ~out_ready;
         n++;
      end
      check("bytes_reached", 128'(obs_b.size() >= target), 128'(1));
   endtask

   task automatic wait_reads(input int target);
      int n;
      n = 0;
      while (data_rd < target && n < 3000) begin
         cycles(1);
         n++;
      end
      check("reads_reached", 128'(data_rd >= target), 128'(1));
   endtask

   task automatic compare_bytes(input int n);
      logic [127:0] got;
      for (int k = 0; k < n; k++) begin
         got = '1;
         if (obs_bi < obs_b.size()) got = 128'(obs_b[obs_bi]);
         check("byte", got, 128'(exp_b.pop_front()));
         obs_bi++;
      end
   endtask

   task automatic compare_all();
      logic [127:0] got;
      compare_bytes(exp_b.size());
      check("byte_count", 128'(obs_b.size()), 128'(obs_bi));
      while (exp_h.size() > 0) begin
         got = '1;
         if (obs_hi < obs_h.size()) got = 128'(obs_h[obs_hi]);
         check("hdr", got, 128'(exp_h.pop_front()));
         obs_hi++;
      end
      check("hdr_count", 128'(obs_h.size()), 128'(obs_hi));
   endtask

   initial begin
      int r0, p0, b0;
      longint t0;
      rstn = 1'b0; out_ready = 1'b1; hdr_ready = 1'b1;
      cycles(3);
      check("rst_ptr_rd", 128'(ptr_fifo_rd), 128'(0));
      check("rst_data_rd", 128'(data_fifo_rd), 128'(0));
      check("rst_out_valid", 128'(out_valid), 128'(0));
      check("rst_hdr_valid", 128'(hdr_valid), 128'(0));
      check("rst_counters", 128'({runt_cnt, err_cnt}), 128'(0));
      check("rst_hdr_fields", 128'({hdr_da, hdr_sa, hdr_etype, hdr_len}), 128'(0));
      rstn = 1'b1;
      cycles(2);

      // Good 64-byte frame, full throughput
      r0 = data_rd; t0 = $time;
      send_frame(64, 1'b0, 1'b1, 1);
      wait_bytes(obs_bi + 64, 1'b0);
      check("throughput", 128'((($time - t0) / 10) <= 72), 128'(1));
      cycles(5);
      check("good_reads", 128'(data_rd - r0), 128'(64));
      compare_all();

      // Error frame: drained, nothing forwarded
      r0 = data_rd;
      send_frame(64, 1'b1, 1'b0, 2);
      wait_reads(r0 + 64);
      cycles(6);
      check("err_reads", 128'(data_rd - r0), 128'(64));
      check("err_no_bytes", 128'(obs_b.size()), 128'(obs_bi));
      check("err_no_hdr", 128'(obs_h.size()), 128'(obs_hi));
      check("err_cnt", 128'(err_cnt), 128'(1));

      // Runt of 10, then zero-length
      r0 = data_rd;
      send_frame(10, 1'b0, 1'b0, 3);
      wait_reads(r0 + 10);
      cycles(6);
      check("runt_reads", 128'(data_rd - r0), 128'(10));
      check("runt_cnt1", 128'(runt_cnt), 128'(1));
      r0 = data_rd; p0 = ptr_pop;
      send_frame(0, 1'b0, 1'b0, 4);
      cycles(8);
      check("zero_popped", 128'(ptr_pop - p0), 128'(1));
      check("zero_reads", 128'(data_rd - r0), 128'(0));
      check("runt_cnt2", 128'(runt_cnt), 128'(2));
      check("runt_no_bytes", 128'(obs_b.size()), 128'(obs_bi));

      // Two back-to-back 60-byte frames with out_ready toggling
      send_frame(60, 1'b0, 1'b1, 5);
      send_frame(60, 1'b0, 1'b1, 6);
      wait_bytes(obs_bi + 120, 1'b1);
      out_ready = 1'b1;
      cycles(6);
      compare_all();

      // Header backpressure withholds the next descriptor pop
      hdr_ready = 1'b0; p0 = ptr_pop; b0 = obs_bi;
      send_frame(20, 1'b0, 1'b1, 7);
      send_frame(20, 1'b0, 1'b1, 8);
      wait_bytes(b0 + 20, 1'b0);
      cycles(10);
      check("hold_pops", 128'(ptr_pop - p0), 128'(1));
      check("hold_ptr_rd", 128'(ptr_fifo_rd), 128'(0));
      check("hold_hdr_valid", 128'(hdr_valid), 128'(1));
      check("hold_hdr_fields", 128'({hdr_da, hdr_sa, hdr_etype, hdr_len}), 128'(exp_h[0]));
      hdr_ready = 1'b1;
      wait_bytes(b0 + 40, 1'b0);
      cycles(6);
      check("release_pops", 128'(ptr_pop - p0), 128'(2));
      compare_all();

      // Reset at byte 30 of a 64-byte frame
      b0 = obs_bi;
      send_frame(64, 1'b0, 1'b1, 9);
      wait_bytes(b0 + 30, 1'b0);
      rstn = 1'b0;
      #1;
      check("midrst_out_valid", 128'(out_valid), 128'(0));
      check("midrst_hdr_valid", 128'(hdr_valid), 128'(0));
      check("midrst_rd", 128'({ptr_fifo_rd, data_fifo_rd}), 128'(0));
      check("midrst_counters", 128'({runt_cnt, err_cnt}), 128'(0));
      check("midrst_hdr_fields", 128'({hdr_da, hdr_sa, hdr_etype, hdr_len}), 128'(0));
      compare_bytes(obs_b.size() - obs_bi);
      exp_b.delete();
      cycles(2);
      rstn = 1'b1;
      cycles(2);
      r0 = data_rd;
      send_frame(64, 1'b0, 1'b1, 10);
      wait_bytes(obs_bi + 64, 1'b0);
      cycles(6);
      check("post_rst_reads", 128'(data_rd - r0), 128'(64));
      compare_all();

      check("fifo_underflow", 128'(underflow), 128'(0));
      check("stream_stable", 128'(stab_viol), 128'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
